// File: rtl/pixel_stream_source_pkg.sv
// Shared definitions for the pixel stream source: FSM encoding, default
// widths and the read-to-output pipeline latency.
package pixel_stream_source_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_STREAM = 3'd1;
  localparam state_t ST_DRAIN  = 3'd2;
  localparam state_t ST_FLUSH  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  localparam int PIX_W_DEFAULT = 8;

  // Cycles from a memory read strobe to the matching enb on the stream.
  localparam int RD_LATENCY = 2;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_stream_source_if.sv
// Frame-store read port plus the outgoing pixel stream towards the
// smoothing filter. master = the source, slave = memory/filter side.
interface pixel_stream_source_if
  import pixel_stream_source_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int PIX_W  = PIX_W_DEFAULT
);

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic              hold;
  logic              enb;
  logic [PIX_W-1:0]  pixel_out;
  logic              row_start;

  modport master (
    output mem_rd_en, mem_addr, enb, pixel_out, row_start,
    input  mem_rdata, hold
  );

  modport slave (
    input  mem_rd_en, mem_addr, enb, pixel_out, row_start,
    output mem_rdata, hold
  );

endinterface

// File: rtl/pixel_stream_source_raster_counter.sv
// Raster position tracker: column, row and linear address advance together
// on each issued read and wrap back to zero after the last pixel.
module raster_counter
  import pixel_stream_source_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              col_zero,
  output logic              last
);

  localparam int CW = width_min1(IMG_W);
  localparam int RW = width_min1(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_end;

  assign col_end  = (col == COL_MAX);
  assign last     = col_end && (row == ROW_MAX);
  assign col_zero = (col == '0);

  // Step through the frame in raster order; the address is a plain
  // incrementing counter so no row*width product is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      addr <= last ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/pixel_stream_source.sv
// Reads a stored greyscale frame and streams it in raster order to the
// smoothing filter, followed by pad pixels that drain the filter pipeline.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | issuing one memory read per cycle unless hold is high
// DRAIN  | last read in flight; its data lands in pixel_out on exit
// FLUSH  | emitting pad pixels, one per cycle unless hold is high
// DONE   | frame_done is registered on the exit edge, then back to IDLE
module pixel_stream_source
  import pixel_stream_source_pkg::*;
#(
  parameter int IMG_W        = 8,
  parameter int IMG_H        = 8,
  parameter int PIX_W        = PIX_W_DEFAULT,
  parameter int ADDR_W       = 6,
  parameter int FLUSH_CYCLES = 3,
  parameter int PAD_VAL      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  pixel_stream_source_if.master bus,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int PCW = width_min1(FLUSH_CYCLES + 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic              col_zero;
  logic              rc_last;
  logic              rd_issue;
  logic              pad_emit;
  logic              rd_q;
  logic              rs_q;
  logic [PCW-1:0]    pad_cnt;

  assign rd_issue      = (state == ST_STREAM) && !bus.hold;
  assign pad_emit      = (state == ST_FLUSH) && !bus.hold;
  assign bus.mem_rd_en = rd_issue;
  assign bus.mem_addr  = addr;
  assign busy          = (state != ST_IDLE);

  raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk      (clk),
    .rst      (reset),
    .advance  (rd_issue),
    .addr     (addr),
    .col_zero (col_zero),
    .last     (rc_last)
  );

  // Next-state decode. DRAIN is entered on the edge that issues the last
  // read, so exactly one cycle later that data is captured and nothing is
  // left in flight; pads can then follow the last pixel with no gap.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_STREAM;
      ST_STREAM: if (rd_issue && rc_last) state_nx = ST_DRAIN;
      ST_DRAIN:  state_nx = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_DONE;
      ST_FLUSH:  if (pad_emit && (pad_cnt == PCW'(1))) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Pad counter: loaded while draining, counts down per emitted pad.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  pad_cnt <= '0;
    else if (state == ST_DRAIN) pad_cnt <= PCW'(FLUSH_CYCLES);
    else if (pad_emit)          pad_cnt <= pad_cnt - 1'b1;
  end

  // Output pipeline: read valid and row flag follow the strobe by one
  // cycle, then the memory data is registered onto the stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q          <= 1'b0;
      rs_q          <= 1'b0;
      bus.enb       <= 1'b0;
      bus.row_start <= 1'b0;
      bus.pixel_out <= '0;
      frame_done    <= 1'b0;
    end else begin
      rd_q          <= rd_issue;
      rs_q          <= rd_issue && col_zero;
      bus.enb       <= rd_q || pad_emit;
      bus.row_start <= rd_q && rs_q;
      frame_done    <= (state == ST_DONE);
      if (rd_q)          bus.pixel_out <= bus.mem_rdata;
      else if (pad_emit) bus.pixel_out <= PIX_W'(PAD_VAL);
    end
  end

endmodule

// File: tb/tb_pixel_stream_source.sv
// Self-checking bench: exact-timing vector table for a plain frame, a
// scoreboard on the stream for hold/restart/reset sequences, and a 1x1
// frame with no flush padding on a second instance.
module tb_pixel_stream_source;
  import pixel_stream_source_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start1, start2;
  logic busy1, fd1, busy2, fd2;

  always #5 clk = ~clk;

  pixel_stream_source_if #(.ADDR_W(6), .PIX_W(8)) bus1();
  pixel_stream_source_if #(.ADDR_W(6), .PIX_W(8)) bus2();

  pixel_stream_source #(
    .IMG_W(4), .IMG_H(2), .PIX_W(8), .ADDR_W(6), .FLUSH_CYCLES(3), .PAD_VAL(0)
  ) dut1 (
    .clk(clk), .reset(rst), .start(start1), .bus(bus1),
    .busy(busy1), .frame_done(fd1)
  );

  pixel_stream_source #(
    .IMG_W(1), .IMG_H(1), .PIX_W(8), .ADDR_W(6), .FLUSH_CYCLES(0), .PAD_VAL(0)
  ) dut2 (
    .clk(clk), .reset(rst), .start(start2), .bus(bus2),
    .busy(busy2), .frame_done(fd2)
  );

  // Frame store model: mem[a] = a + 4, synchronous read.
  always @(posedge clk) begin
    if (bus1.mem_rd_en) bus1.mem_rdata <= 8'(bus1.mem_addr) + 8'd4;
    if (bus2.mem_rd_en) bus2.mem_rdata <= 8'(bus2.mem_addr) + 8'd4;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected stream beats.
  typedef struct packed { logic [7:0] pix; logic rs; } exp_t;
  exp_t q[$];

  int mon_cyc   = 0;
  int mon_first = -1;
  int mon_last  = -1;
  int fd_cnt    = 0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      mon_cyc++;
      if (bus1.enb) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_stray_pixel: got pixel %0d with no beat expected at %0t",
                   bus1.pixel_out, $time);
        end else begin
          e = q.pop_front();
          check("sb_pixel", 32'(bus1.pixel_out), 32'(e.pix));
          check("sb_row_start", 32'(bus1.row_start), 32'(e.rs));
        end
        if (mon_first < 0) mon_first = mon_cyc;
        mon_last = mon_cyc;
      end
      if (fd1) fd_cnt++;
    end
  end

  task automatic push_frame();
    for (int i = 0; i < 8; i++) q.push_back('{pix: 8'(i + 4), rs: (i % 4 == 0)});
    for (int i = 0; i < 3; i++) q.push_back('{pix: 8'd0, rs: 1'b0});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start so the next edge (k) samples it; returns at k+#1.
  task automatic start_frame();
    start1 = 1'b1;
    push_frame();
    tick();
    start1 = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int fd0;
    fd0 = fd_cnt;
    for (int i = 0; i < 60 && fd_cnt == fd0; i++) tick();
    check({name, "_done"}, fd_cnt - fd0, 1);
    repeat (4) tick();
    check({name, "_done_once"}, fd_cnt - fd0, 1);
    check({name, "_sb_empty"}, q.size(), 0);
  endtask

  // Cycle-exact expectations after edge k+j for the plain 4x2 frame.
  typedef struct {
    int j; int rd; int addr; int enb; int pix; int rs; int busy; int fd;
  } vec_t;
  vec_t tbl[15];

  initial begin
    int first;
    int fd0;
    //             j  rd addr enb pix rs busy fd
    tbl[0]  = '{ 0, 1, 0, 0,  0, 0, 1, 0};
    tbl[1]  = '{ 1, 1, 1, 0,  0, 0, 1, 0};
    tbl[2]  = '{ 2, 1, 2, 1,  4, 1, 1, 0};
    tbl[3]  = '{ 3, 1, 3, 1,  5, 0, 1, 0};
    tbl[4]  = '{ 4, 1, 4, 1,  6, 0, 1, 0};
    tbl[5]  = '{ 5, 1, 5, 1,  7, 0, 1, 0};
    tbl[6]  = '{ 6, 1, 6, 1,  8, 1, 1, 0};
    tbl[7]  = '{ 7, 1, 7, 1,  9, 0, 1, 0};
    tbl[8]  = '{ 8, 0, 0, 1, 10, 0, 1, 0};
    tbl[9]  = '{ 9, 0, 0, 1, 11, 0, 1, 0};
    tbl[10] = '{10, 0, 0, 1,  0, 0, 1, 0};
    tbl[11] = '{11, 0, 0, 1,  0, 0, 1, 0};
    tbl[12] = '{12, 0, 0, 1,  0, 0, 1, 0};
    tbl[13] = '{13, 0, 0, 0,  0, 0, 0, 1};
    tbl[14] = '{14, 0, 0, 0,  0, 0, 0, 0};

    rst = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    bus1.hold = 1'b0;
    bus2.hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    check("rst_enb", 32'(bus1.enb), 0);
    check("rst_pixel", 32'(bus1.pixel_out), 0);
    check("rst_row_start", 32'(bus1.row_start), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_rd_en", 32'(bus1.mem_rd_en), 0);
    check("rst_frame_done", 32'(fd1), 0);

    // Plain frame, exact timing.
    start_frame();
    first = -1;
    for (int j = 0; j < 15; j++) begin
      if (j > 0) tick();
      check($sformatf("t%0d_rd_en", j), 32'(bus1.mem_rd_en), tbl[j].rd);
      if (tbl[j].rd != 0) check($sformatf("t%0d_addr", j), 32'(bus1.mem_addr), tbl[j].addr);
      check($sformatf("t%0d_enb", j), 32'(bus1.enb), tbl[j].enb);
      check($sformatf("t%0d_pixel", j), 32'(bus1.pixel_out), tbl[j].pix);
      check($sformatf("t%0d_row_start", j), 32'(bus1.row_start), tbl[j].rs);
      check($sformatf("t%0d_busy", j), 32'(busy1), tbl[j].busy);
      check($sformatf("t%0d_frame_done", j), 32'(fd1), tbl[j].fd);
      if (bus1.enb && first < 0) first = j;
    end
    check("latency", first, RD_LATENCY);
    check("plain_sb_empty", q.size(), 0);

    // Hold for two cycles while addr 2 is next to issue.
    tick();
    mon_first = -1;
    mon_last = -1;
    start_frame();
    tick();
    tick();
    bus1.hold = 1'b1;
    #1;
    check("hold_rd_en_a", 32'(bus1.mem_rd_en), 0);
    check("hold_addr_frozen_a", 32'(bus1.mem_addr), 2);
    tick();
    check("hold_rd_en_b", 32'(bus1.mem_rd_en), 0);
    check("hold_addr_frozen_b", 32'(bus1.mem_addr), 2);
    tick();
    bus1.hold = 1'b0;
    #1;
    check("hold_release_rd_en", 32'(bus1.mem_rd_en), 1);
    check("hold_release_addr", 32'(bus1.mem_addr), 2);
    wait_done("hold");
    check("hold_span", mon_last - mon_first + 1, 13);

    // Start pulsed again mid-frame must be ignored.
    start_frame();
    repeat (4) tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done("restart");
    check("restart_idle", 32'(busy1), 0);

    // Async reset mid-frame, right after pixel 6 has been emitted.
    start_frame();
    repeat (4) tick();
    #5;
    rst = 1'b1;
    #1;
    check("arst_enb", 32'(bus1.enb), 0);
    check("arst_pixel", 32'(bus1.pixel_out), 0);
    check("arst_busy", 32'(busy1), 0);
    check("arst_rd_en", 32'(bus1.mem_rd_en), 0);
    q.delete();
    fd0 = fd_cnt;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("arst_no_done", fd_cnt - fd0, 0);
    start_frame();
    wait_done("after_reset");

    // 1x1 frame, no flush pads.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("one_rd_en", 32'(bus2.mem_rd_en), 1);
    check("one_addr", 32'(bus2.mem_addr), 0);
    tick();
    check("one_rd_en_off", 32'(bus2.mem_rd_en), 0);
    check("one_enb_wait", 32'(bus2.enb), 0);
    check("one_busy_drain", 32'(busy2), 1);
    tick();
    check("one_enb", 32'(bus2.enb), 1);
    check("one_pixel", 32'(bus2.pixel_out), 4);
    check("one_row_start", 32'(bus2.row_start), 1);
    check("one_done_early", 32'(fd2), 0);
    tick();
    check("one_no_pad", 32'(bus2.enb), 0);
    check("one_done", 32'(fd2), 1);
    check("one_busy_low", 32'(busy2), 0);
    tick();
    check("one_done_pulse", 32'(fd2), 0);
    check("one_no_pad_late", 32'(bus2.enb), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pixel_stream_source.md
Name: pixel_stream_source

Overview:
- Streaming source that reads a stored greyscale frame from a synchronous-read image memory.
- Presents the frame in raster order as an 8-bit pixel stream qualified by enb, matching the input side of the smoothing filter (clk, reset, enb, 8-bit pixel).
- After the last pixel it appends pad pixels so the filter pipeline drains, then signals frame completion.
- Sits between the frame store and the smoothing filter stage of the edge-detection chain.

Parameters:
- IMG_W, 8, pixels per row (≥1).
- IMG_H, 8, rows per frame (≥1).
- PIX_W, 8, pixel width.
- ADDR_W, 6, memory address width; IMG_W*IMG_H ≤ 2^ADDR_W.
- FLUSH_CYCLES, 3, pad pixels emitted after the last real pixel (may be 0).
- PAD_VAL, 0, pad pixel value.

Ports:
- clk, in, 1, single clock; all logic on the rising edge.
- reset, in, 1, asynchronous, active-high reset.
- start, in, 1, begin a frame; sampled only in IDLE.
- hold, in, 1, downstream stall; while high, no new memory read is issued.
- mem_rd_en, out, 1, memory read strobe.
- mem_addr, out, ADDR_W, read address, linear raster index.
- mem_rdata, in, PIX_W, read data, valid the cycle after mem_rd_en.
- enb, out, 1, pixel_out valid; drives the filter enable.
- pixel_out, out, PIX_W, streamed pixel.
- row_start, out, 1, high with the first pixel of each row.
- busy, out, 1, high whenever the FSM is not in IDLE.
- frame_done, out, 1, one-cycle pulse at frame end.

Behaviour:
- Reset (async): all outputs 0, FSM IDLE, counters 0, pipeline valid bits cleared. Reset mid-frame abandons the frame; no frame_done is produced.
- FSM states: IDLE, STREAM, DRAIN, FLUSH, DONE.
- IDLE: start=1 at edge k → STREAM. In the cycle after k, mem_rd_en=1 with mem_addr=0.
- STREAM:
  - Each cycle with hold=0: mem_rd_en=1, issue the current addr, then advance col/row/addr.
  - col wraps from IMG_W-1 to 0 and increments row.
  - With hold=1: mem_rd_en=0 and counters frozen.
  - After the read of addr IMG_W*IMG_H-1 issues → DRAIN.
- Data pipeline:
  - A read valid bit (rd_q) follows mem_rd_en by one cycle.
  - When rd_q=1, mem_rdata is registered into pixel_out and enb=1 on the following cycle.
  - Latency is 2 cycles from read issue to enb. The first pixel appears after edge k+2.
  - enb is never high without a preceding read or a pad.
  - hold is not a combinational stall: up to 2 pixels already in flight still emerge after hold rises. No pixel is ever duplicated or skipped.
- row_start: registered alongside pixel_out; high exactly when the emitted pixel has col=0.
- DRAIN: waits until no read is in flight (rd_q=0 and the last pixel is registered).
  - FLUSH_CYCLES>0 → FLUSH.
  - FLUSH_CYCLES=0 → DONE.
- FLUSH:
  - Each cycle with hold=0: emit pad (enb=1, pixel_out=PAD_VAL) and decrement the pad counter.
  - hold=1: enb=0.
  - Last pad emitted → DONE.
  - Pads immediately follow the last real pixel when hold=0 (no gap).
- DONE: frame_done=1 for one cycle, then → IDLE. busy drops in the same cycle frame_done pulses high.
- start while busy is ignored; start held high in IDLE after DONE begins a new frame.
- hold in IDLE or DONE has no effect.
- When enb=0, pixel_out holds its last value; consumers qualify with enb.
- Counter widths: col $clog2(IMG_W), row $clog2(IMG_H), pad counter $clog2(FLUSH_CYCLES+1), each min 1. Address is an incrementing counter; no multiply.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE, ST_STREAM, ST_DRAIN, ST_FLUSH, ST_DONE);
  - default PIX_W=8;
  - the 2-cycle read-to-output latency constant, used by the bench.
- One natural sub-module: raster_counter, holding col/row/addr with an advance input and last/row-start flags.

Test Plan:
- IMG_W=4, IMG_H=2, mem[a]=a+4, FLUSH_CYCLES=3, hold=0, start pulse at edge k → enb high after edges k+2..k+9 with pixel_out 4..11. Then 3 pads (0) at k+10..k+12, frame_done pulse after k+13, busy low from then.
- Same frame, hold=1 for 2 cycles while addr=2 is next to issue → output sequence still 4..11 with a gap of 2 enb-low cycles, no duplicate or missing value.
- row_start → high only alongside pixel_out=4 and pixel_out=8.
- start pulsed again mid-frame → ignored; exactly one frame_done; pixel sequence unchanged.
- reset asserted asynchronously mid-frame (after pixel 6) → enb, pixel_out, busy, mem_rd_en go 0 immediately; no frame_done. A fresh start then replays 4..11 correctly.
- FLUSH_CYCLES=0, IMG_W=1, IMG_H=1 → a single pixel 4 with row_start=1, then frame_done on the cycle after DRAIN, no pads.
